// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
// Holds the FSM state encoding, operand/product widths and the width
// helpers used to size the owner index and settle counter.
package mul_share_pkg;

   localparam int OPW   = 16;
   localparam int PRODW = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int owner_width(input int nreq);
      return width_of(nreq);
   endfunction

   // The counter is loaded with MUL_CYCLES-1 and counts down to zero.
   function automatic int cnt_width(input int mul_cycles);
      return width_of(mul_cycles);
   endfunction

endpackage

// File: rtl/mul_share_ctrl_mult_cell.sv
// Combinational 16x16 unsigned array multiplier.
// Built from shifted partial products summed in a ripple chain; the long
// path is why the controller gives it several cycles to settle.
module MULTPLY_CELL
   import mul_share_pkg::*;
(
   input  logic [OPW-1:0]   iA,
   input  logic [OPW-1:0]   iB,
   output logic [PRODW-1:0] oP
);

   logic [PRODW-1:0] pp [OPW];
   logic [PRODW-1:0] sum;

   genvar gi;
   generate
      for (gi = 0; gi < OPW; gi++) begin : g_pp
         assign pp[gi] = iB[gi] ? ({{(PRODW-OPW){1'b0}}, iA} << gi) : '0;
      end
   endgenerate

   // Accumulate the partial products row by row.
   always_comb begin
      sum = '0;
      for (int i = 0; i < OPW; i++) begin
         sum = sum + pp[i];
      end
   end

   assign oP = sum;

endmodule

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Request arbiter for the shared multiplier.
// Default: round-robin, the requester at iPtr has highest priority and the
// search wraps from NREQ-1 back to 0.
// With MUL_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and the pointer port disappears.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] iReq,
`ifndef MUL_ARB_FIXED_PRIO_EN
   input  logic [IW-1:0]   iPtr,
`endif
   output logic [NREQ-1:0] oWin,
   output logic [IW-1:0]   oIdx
);

`ifdef MUL_ARB_FIXED_PRIO_EN
   // Scan from the top so the lowest requesting index is the last write.
   always_comb begin
      oWin = '0;
      oIdx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (iReq[k]) begin
            oWin    = '0;
            oWin[k] = 1'b1;
            oIdx    = IW'(k);
         end
      end
   end
`else
   // Walk the requesters starting at the pointer; first one found wins.
   always_comb begin
      int  j;
      logic found;
      oWin  = '0;
      oIdx  = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(iPtr) + k;
         if (j >= NREQ) begin
            j = j - NREQ;
         end
         if (!found && iReq[j]) begin
            found   = 1'b1;
            oWin[j] = 1'b1;
            oIdx    = IW'(j);
         end
      end
   end
`endif

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one MULTPLY_CELL among NREQ requesters.
// IDLE arbitrates and captures the winner's operands, CALC waits MUL_CYCLES
// for the multiplier to settle and captures the product, DONE pulses oDone
// to the owner. All outputs are registered.
// Build option: MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// and removes the round-robin pointer.
module mul_share_ctrl
   import mul_share_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int MUL_CYCLES = 3
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [NREQ-1:0]     iReq,
   input  logic [OPW*NREQ-1:0] iA,
   input  logic [OPW*NREQ-1:0] iB,
   output logic [NREQ-1:0]     oGnt,
   output logic [NREQ-1:0]     oDone,
   output logic [PRODW-1:0]    oR,
   output logic                oBusy
);

   localparam int OW = owner_width(NREQ);
   localparam int CW = cnt_width(MUL_CYCLES);

   state_t           state_q, state_d;
   logic [OPW-1:0]   ra_q, ra_d;
   logic [OPW-1:0]   rb_q, rb_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic [PRODW-1:0] r_q, r_d;
   logic             busy_q, busy_d;
`ifndef MUL_ARB_FIXED_PRIO_EN
   logic [OW-1:0]    ptr_q, ptr_d;
`endif

   logic [OPW-1:0]   a_slice [NREQ];
   logic [OPW-1:0]   b_slice [NREQ];
   logic [NREQ-1:0]  win_onehot;
   logic [OW-1:0]    win_idx;
   logic [PRODW-1:0] product;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_slice[gi] = iA[OPW*gi +: OPW];
         assign b_slice[gi] = iB[OPW*gi +: OPW];
      end
   endgenerate

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (OW)
   ) u_arb (
      .iReq (iReq),
`ifndef MUL_ARB_FIXED_PRIO_EN
      .iPtr (ptr_q),
`endif
      .oWin (win_onehot),
      .oIdx (win_idx)
   );

   // The multiplier only ever sees the captured operands.
   MULTPLY_CELL u_mul (
      .iA (ra_q),
      .iB (rb_q),
      .oP (product)
   );

   // Next-state and registered-output logic for the sharing FSM.
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      gnt_d   = '0;
      done_d  = '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|iReq) begin
               ra_d    = a_slice[win_idx];
               rb_d    = b_slice[win_idx];
               owner_d = win_idx;
               gnt_d   = win_onehot;
               cnt_d   = CW'(MUL_CYCLES - 1);
`ifndef MUL_ARB_FIXED_PRIO_EN
               ptr_d   = (win_idx == OW'(NREQ - 1)) ? '0 : win_idx + OW'(1);
`endif
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (cnt_q == '0) begin
               r_d     = product;
               done_d  = NREQ'(1) << owner_q;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
`ifndef MUL_ARB_FIXED_PRIO_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
`ifndef MUL_ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign oGnt  = gnt_q;
   assign oDone = done_q;
   assign oR    = r_q;
   assign oBusy = busy_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed testbench for mul_share_ctrl (NREQ=4, MUL_CYCLES=3).
// Timing used throughout: the grant shows in cycle C0, oDone and the new
// product show in C3, oBusy is low in C4 and a held request is captured so
// that the next grant shows in C5.
module tb_mul_share_ctrl;

   logic        Clock;
   logic        Reset;
   logic [3:0]  iReq;
   logic [63:0] iA;
   logic [63:0] iB;
   logic [3:0]  oGnt;
   logic [3:0]  oDone;
   logic [31:0] oR;
   logic        oBusy;

   int n_cmp = 0;
   int n_err = 0;

   mul_share_ctrl #(
      .NREQ       (4),
      .MUL_CYCLES (3)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .iReq  (iReq),
      .iA    (iA),
      .iB    (iB),
      .oGnt  (oGnt),
      .oDone (oDone),
      .oR    (oR),
      .oBusy (oBusy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for any grant after the request was driven.
   task automatic wait_gnt();
      tick();
      for (int c = 0; c < 10 && oGnt == 4'b0; c++) begin
         tick();
      end
   endtask

   // One isolated operation; the requester drops iReq and scrambles its
   // operands right after the grant, which must not affect the result.
   task automatic run_single(input string tag, input int idx,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] exp_prod);
      logic [31:0] prev_r;
      prev_r = oR;
      iReq = 4'b0;
      iReq[idx] = 1'b1;
      iA[16*idx +: 16] = a;
      iB[16*idx +: 16] = b;
      wait_gnt();
      $display("op %s: req %0d A=%h B=%h", tag, idx, a, b);
      check({tag, "_gnt"}, 32'(oGnt), 32'(4'b1 << idx));
      check({tag, "_done_c0"}, 32'(oDone), 32'h0);
      iReq = 4'b0;
      iA[16*idx +: 16] = ~a;
      iB[16*idx +: 16] = ~b;
      tick();
      check({tag, "_busy_c1"}, 32'(oBusy), 32'h1);
      check({tag, "_done_c1"}, 32'(oDone), 32'h0);
      check({tag, "_r_hold_c1"}, oR, prev_r);
      tick();
      check({tag, "_done_c2"}, 32'(oDone), 32'h0);
      tick();
      check({tag, "_done"}, 32'(oDone), 32'(4'b1 << idx));
      check({tag, "_r"}, oR, exp_prod);
      check({tag, "_gnt_c3"}, 32'(oGnt), 32'h0);
      tick();
      check({tag, "_busy_c4"}, 32'(oBusy), 32'h0);
      check({tag, "_done_c4"}, 32'(oDone), 32'h0);
      check({tag, "_r_c4"}, oR, exp_prod);
   endtask

   initial begin
      int          exp_idx [5];
      logic [31:0] prod_tab [4];
      logic [31:0] prev_exp;
      logic [3:0]  done_seen;
      logic        busy_seen;
      int          idx;

`ifdef MUL_ARB_FIXED_PRIO_EN
      exp_idx = '{0, 0, 0, 0, 0};
`else
      exp_idx = '{0, 1, 2, 3, 0};
`endif
      prod_tab = '{32'h0000_0110, 32'h0001_2300, 32'h0000_2468, 32'h0000_FFFF};

      Reset = 1'b1;
      iReq  = 4'b0;
      iA    = '0;
      iB    = '0;

      // Reset state
      #3;
      check("rst_gnt",  32'(oGnt),  32'h0);
      check("rst_done", 32'(oDone), 32'h0);
      check("rst_r",    oR,         32'h0);
      check("rst_busy", 32'(oBusy), 32'h0);
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      tick();

      // Basic op: 3 * 5
      run_single("t2_3x5", 0, 16'h0003, 16'h0005, 32'h0000_000F);

      // Reset mid-CALC aborts the op and clears outputs at once
      iReq = 4'b0001;
      iA[15:0] = 16'h0007;
      iB[15:0] = 16'h0009;
      wait_gnt();
      $display("op t1_abort: req 0 A=0007 B=0009, reset in CALC");
      check("t1_gnt", 32'(oGnt), 32'h1);
      tick();
      iReq = 4'b0;
      check("t1_busy_calc", 32'(oBusy), 32'h1);
      #2;
      Reset = 1'b1;
      #1;
      check("t1_rst_gnt",  32'(oGnt),  32'h0);
      check("t1_rst_done", 32'(oDone), 32'h0);
      check("t1_rst_r",    oR,         32'h0);
      check("t1_rst_busy", 32'(oBusy), 32'h0);
      @(negedge Clock);
      Reset = 1'b0;
      done_seen = 4'b0;
      busy_seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         done_seen = done_seen | oDone;
         busy_seen = busy_seen | oBusy;
      end
      check("t1_no_done", 32'(done_seen), 32'h0);
      check("t1_no_busy", 32'(busy_seen), 32'h0);

      // All four request continuously: arbitration order, busy gap, oR hold
      iA = {16'hFFFF, 16'h1234, 16'h0123, 16'h0011};
      iB = {16'h0001, 16'h0002, 16'h0100, 16'h0010};
      iReq = 4'b1111;
      prev_exp = 32'h0;
      wait_gnt();
      for (int k = 0; k < 5; k++) begin
         idx = exp_idx[k];
         $display("op t3_rr%0d: expect grant to requester %0d", k, idx);
         check("t3_gnt",     32'(oGnt),  32'(4'b1 << idx));
         check("t3_done_c0", 32'(oDone), 32'h0);
         check("t3_busy_c0", 32'(oBusy), 32'h1);
         if (k == 4) begin
            iReq = 4'b0;
         end
         tick();
         check("t3_r_hold_c1", oR, prev_exp);
         tick();
         check("t3_r_hold_c2", oR, prev_exp);
         check("t3_busy_c2",   32'(oBusy), 32'h1);
         tick();
         check("t3_done", 32'(oDone), 32'(4'b1 << idx));
         check("t3_r",    oR, prod_tab[idx]);
         prev_exp = prod_tab[idx];
         tick();
         check("t3_busy_gap", 32'(oBusy), 32'h0);
         check("t3_gnt_c4",   32'(oGnt),  32'h0);
         check("t3_r_c4",     oR, prev_exp);
         tick();
      end
      check("t3_idle_busy", 32'(oBusy), 32'h0);
      check("t3_idle_gnt",  32'(oGnt),  32'h0);

      // Arithmetic corners
      run_single("t4_ffff", 0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
      run_single("t4_8000", 1, 16'h8000, 16'h0002, 32'h0001_0000);

      // Requester 2 changes its inputs after the grant
      run_single("t5_req2", 2, 16'h0100, 16'h0030, 32'h0000_3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end

endmodule
